fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-side controller of the async FIFO. It sits directly upstream of the dual-clock storage array in the write clock domain and accepts push requests from the producer. It generates the array's write enable and write address, publishes a Gray-coded write pointer to the read domain, and synchronizes the read domain's Gray pointer. From that pointer it derives a registered, conservative full flag and a sticky overflow flag.

## Interface
- ADDRSIZE, 4, address width; FIFO depth DEEPTH = 2**ADDRSIZE.
- SYNC_STAGES, 2, flops in the read-pointer synchronizer; legal values are 2 and up.
- AFULL_THRESH, DEEPTH-2, almost-full threshold in entries; exists only with ALMOST_FULL_EN.
- wr_clk  in  1  write-domain clock; the only clock of this block.
- wr_rst  in  1  reset, synchronous, active-high.
- wr_req  in  1  producer push request; write data goes directly to the array.
- rd_gptr  in  ADDRSIZE+1  read pointer in Gray code, driven from the rd_clk domain (asynchronous to wr_clk).
- wr_en  out  1  array write enable = wr_req & ~wr_full (combinational).
- wr_addr  out  ADDRSIZE  array write address = low ADDRSIZE bits of the binary write pointer.
- wr_gptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
- wr_full  out  1  registered full flag.
- wr_overflow  out  1  sticky flag: a push was attempted while full.
- wr_level  out  ADDRSIZE+1  registered fill estimate; only with ALMOST_FULL_EN.
- wr_almost_full  out  1  registered, level ≥ AFULL_THRESH; only with ALMOST_FULL_EN.

## Operation
- State:
  - wbin: ADDRSIZE+1 binary pointer.
  - wr_gptr: Gray copy of wbin.
  - sync chain: SYNC_STAGES × (ADDRSIZE+1) flops; the last stage is rq_gptr.
  - wr_full and wr_overflow registers.
- Push: on an edge with wr_en=1:
  - wbin_next = wbin+1, modulo 2^(ADDRSIZE+1).
  - wr_gptr_next = wbin_next ^ (wbin_next>>1).
  - With wr_en=0, the pointers hold.
- Full: wr_full_next = (wr_gptr_next == {~rq_gptr[MSB:MSB-1], rq_gptr[MSB-2:0]}).
  - The two MSBs are inverted; ADDRSIZE=1 uses the same rule.
- Full rejection: a push while wr_full=1 is dropped.
  - wr_en stays 0, the pointer is unchanged, and wr_overflow is set.
  - wr_overflow clears only on wr_rst.
- wr_full is pessimistic:
  - It may stay high after the reader has freed entries.
  - It never stays low when the FIFO is truly full.
- Wrap-around: wr_addr wraps from DEEPTH-1 to 0. The extra MSB toggles on every wrap.
- Simultaneous push and read-pointer change in one edge: the push uses the current wr_full. The new read pointer takes effect through the synchronizer.
- Reset (also mid-operation), at the next edge:
  - wbin, wr_gptr and all sync flops go to 0.
  - wr_full, wr_overflow, wr_level and wr_almost_full go to 0.
  - wr_en is 0 while wr_rst is high.
- The read domain must be reset in the same window. This block does not coordinate cross-domain reset.

## Timing
- wr_en: zero latency from wr_req, gated by the current registered wr_full.
- wr_addr and wr_gptr update on the edge that performs the write.
- wr_full rises on the same edge as the write that fills the last entry. The next cycle shows wr_full=1.
- wr_full falls exactly SYNC_STAGES+1 wr_clk edges after rd_gptr settles to a value that frees space.
- wr_gptr is a pure register output: glitch-free, and exactly one bit changes per increment.
- rd_gptr is sampled only by the first sync flop. No other logic sees it unsynchronized.

## Configuration
- Macro: ALMOST_FULL_EN.
- Defined:
  - wr_level_next = wbin_next − gray2bin(rq_gptr), modulo 2^(ADDRSIZE+1), registered.
  - wr_almost_full_next = (wr_level_next ≥ AFULL_THRESH), registered.
  - Both outputs reset to 0 and are pessimistic, in the same way as wr_full.
- Not defined: wr_level, wr_almost_full, AFULL_THRESH and the gray2bin logic are absent from the module.

## Structure
- Shared package fifo_pkg:
  - constant DEEPTH derivation;
  - bin2gray and gray2bin functions (also used by the read-side controller);
  - the default SYNC_STAGES.
- One sub-module: fifo_gray_sync.
  - Parameterized width and stage count, with synchronous active-high reset.
  - The read-side controller reuses it.

## Test plan
All scenarios use ADDRSIZE=2 and SYNC_STAGES=2.
- Reset: wr_rst high for 2 edges with wr_req=1 → wr_en=0; wr_addr=0, wr_gptr=000, wr_full=0, wr_overflow=0.
- Fill with rd_gptr=000 and wr_req high for 5 cycles:
  - wr_en high for 4 cycles, with wr_addr 0,1,2,3.
  - wr_full=1 after the 4th write edge, with wr_gptr=110.
  - The 5th request is dropped, wr_overflow=1 and the pointer is unchanged.
- Release: from full, rd_gptr changes 000→001 → wr_full=0 exactly 3 edges later. The next wr_req writes at wr_addr=0.
- Wrap with the reader keeping pace, 8 writes → wr_gptr sequence 001,011,010,110,111,101,100,000; wr_addr wraps 3→0; wr_full never asserts.
- Reset mid-fill after 2 writes → next edge gives wr_addr=0, wr_gptr=000, wr_overflow=0, and sync flops cleared.
- With ALMOST_FULL_EN and AFULL_THRESH=3, rd_gptr=000, 3 writes → after the 3rd edge wr_level=3 and wr_almost_full=1; wr_full is still 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: depth derivation, Gray/binary conversion and
// the default synchronizer depth, used by both the write- and read-side controllers.
package fifo_pkg;

    localparam int SYNC_STAGES_DEF = 2;

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    // Conversions work on a 32-bit container; callers zero-extend and keep the low bits.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module fifo_gray_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p [STAGES];

    // Only sync_p[0] samples the foreign-domain input.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_p[i] <= '0;
            end
        end else begin
            sync_p[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: write enable/address, Gray write pointer, full/overflow.
// Optional ALMOST_FULL_EN adds a registered fill level and almost-full flag.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef ALMOST_FULL_EN
    ,
    parameter int AFULL_THRESH = fifo_depth(ADDRSIZE) - 2
`endif
) (
    input  logic                wr_clk,
    input  logic                wr_rst,
    input  logic                wr_req,
    input  logic [ADDRSIZE:0]   rd_gptr,
    output logic                wr_en,
    output logic [ADDRSIZE-1:0] wr_addr,
    output logic [ADDRSIZE:0]   wr_gptr,
    output logic                wr_full,
    output logic                wr_overflow
`ifdef ALMOST_FULL_EN
    ,
    output logic [ADDRSIZE:0]   wr_level,
    output logic                wr_almost_full
`endif
);

    localparam int PTR_W  = ADDRSIZE + 1;
    localparam int DEEPTH = fifo_depth(ADDRSIZE);
    // Full when the write pointer equals the read pointer with its two MSBs inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(DEEPTH + DEEPTH / 2);

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rq_gptr;
    logic [31:0]      gray_next_w;
    logic             unused_gray_hi;

    fifo_gray_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk (wr_clk),
        .rst (wr_rst),
        .d   (rd_gptr),
        .q   (rq_gptr)
    );

    assign wr_en          = wr_req & ~wr_full & ~wr_rst;
    assign wbin_next      = wbin + PTR_W'(wr_en);
    assign gray_next_w    = bin2gray(32'(wbin_next));
    assign wgray_next     = gray_next_w[PTR_W-1:0];
    assign unused_gray_hi = ^gray_next_w[31:PTR_W];
    assign wr_addr        = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wbin        <= '0;
            wr_gptr     <= '0;
            wr_full     <= 1'b0;
            wr_overflow <= 1'b0;
        end else begin
            wbin    <= wbin_next;
            wr_gptr <= wgray_next;
            wr_full <= (wgray_next == (rq_gptr ^ FULL_MASK));
            if (wr_req && wr_full) begin
                wr_overflow <= 1'b1;
            end
        end
    end

`ifdef ALMOST_FULL_EN
    logic [31:0]      rq_bin_w;
    logic [PTR_W-1:0] rq_bin;
    logic [PTR_W-1:0] level_next;
    logic             unused_rbin_hi;

    assign rq_bin_w       = gray2bin(32'(rq_gptr));
    assign rq_bin         = rq_bin_w[PTR_W-1:0];
    assign unused_rbin_hi = ^rq_bin_w[31:PTR_W];
    // Lagging synchronized read pointer makes the level an over-estimate, never an under-estimate.
    assign level_next     = wbin_next - rq_bin;

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_level       <= '0;
            wr_almost_full <= 1'b0;
        end else begin
            wr_level       <= level_next;
            wr_almost_full <= (level_next >= PTR_W'(AFULL_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl with ADDRSIZE=2, SYNC_STAGES=2 (AFULL_THRESH=3 with ALMOST_FULL_EN).
module tb_fifo_wr_ctrl;

    localparam int ADDRSIZE = 2;

    logic       wr_clk;
    logic       wr_rst;
    logic       wr_req;
    logic [2:0] rd_gptr;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [2:0] wr_gptr;
    logic       wr_full;
    logic       wr_overflow;
`ifdef ALMOST_FULL_EN
    logic [2:0] wr_level;
    logic       wr_almost_full;
`endif

    fifo_wr_ctrl #(
        .ADDRSIZE     (ADDRSIZE),
        .SYNC_STAGES  (2)
`ifdef ALMOST_FULL_EN
        ,
        .AFULL_THRESH (3)
`endif
    ) dut (
        .wr_clk         (wr_clk),
        .wr_rst         (wr_rst),
        .wr_req         (wr_req),
        .rd_gptr        (rd_gptr),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_gptr        (wr_gptr),
        .wr_full        (wr_full),
        .wr_overflow    (wr_overflow)
`ifdef ALMOST_FULL_EN
        ,
        .wr_level       (wr_level),
        .wr_almost_full (wr_almost_full)
`endif
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    typedef struct {
        string nm;
        int    en;
        int    addr;
        int    g;
        int    full;
        int    ovf;
        int    lvl;
        int    af;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // A negative expected value marks the field as don't-care for that cycle.
    task automatic chk(input string nm, input string fld, input logic [7:0] act, input int exp);
        logic [7:0] e8;
        if (exp >= 0) begin
            e8 = exp[7:0];
            n_total++;
            if (act !== e8) begin
                $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, e8);
            end else begin
                n_pass++;
            end
        end
    endtask

    always @(negedge wr_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.nm, "wr_en",       8'(wr_en),       e.en);
            chk(e.nm, "wr_addr",     8'(wr_addr),     e.addr);
            chk(e.nm, "wr_gptr",     8'(wr_gptr),     e.g);
            chk(e.nm, "wr_full",     8'(wr_full),     e.full);
            chk(e.nm, "wr_overflow", 8'(wr_overflow), e.ovf);
`ifdef ALMOST_FULL_EN
            chk(e.nm, "wr_level",       8'(wr_level),       e.lvl);
            chk(e.nm, "wr_almost_full", 8'(wr_almost_full), e.af);
`endif
        end
    end

    // Drive inputs just after an edge and queue what the next negedge must show.
    task automatic step(input string nm, input logic rst_v, input logic req_v, input logic [2:0] rd_v,
                        input int en, input int addr, input int g, input int full, input int ovf,
                        input int lvl = -1, input int af = -1);
        exp_t e;
        @(posedge wr_clk);
        #1;
        wr_rst  = rst_v;
        wr_req  = req_v;
        rd_gptr = rd_v;
        e.nm = nm; e.en = en; e.addr = addr; e.g = g; e.full = full; e.ovf = ovf;
        e.lvl = lvl; e.af = af;
        exp_q.push_back(e);
    endtask

    int gseq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    initial begin
        wr_rst  = 1'b1;
        wr_req  = 1'b1;
        rd_gptr = 3'b000;

        step("rst1", 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        step("rst2", 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0);

        step("fill0",    0, 1, 3'b000, 1, 0, 3'b000, 0, 0);
        step("fill1",    0, 1, 3'b000, 1, 1, 3'b001, 0, 0);
        step("fill2",    0, 1, 3'b000, 1, 2, 3'b011, 0, 0);
        step("fill3",    0, 1, 3'b000, 1, 3, 3'b010, 0, 0);
        step("full_req", 0, 1, 3'b000, 0, 0, 3'b110, 1, 0);
        step("ovf",      0, 0, 3'b000, 0, 0, 3'b110, 1, 1);

        step("rel0",   0, 0, 3'b001, 0, 0, 3'b110, 1, 1);
        step("rel1",   0, 0, 3'b001, 0, 0, 3'b110, 1, 1);
        step("rel2",   0, 0, 3'b001, 0, 0, 3'b110, 1, 1);
        step("rel3",   0, 1, 3'b001, 1, 0, 3'b110, 0, 1);
        step("refull", 0, 0, 3'b001, 0, 1, 3'b111, 1, 1);

        step("rst_mid",  1, 0, 3'b000, 0, -1, -1, -1, -1);
        step("rst_done", 0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            step("wrap", 0, 1, 3'(gseq[i]), 1, i % 4, gseq[i], 0, 0);
        end
        step("wrap_end", 0, 0, 3'b000, 0, 0, 3'b000, 0, 0);

        step("mid0",      0, 1, 3'b000, 1, 0, 3'b000, 0, 0);
        step("mid1",      0, 1, 3'b110, 1, 1, 3'b001, 0, 0);
        step("mid_rst",   1, 1, 3'b110, 0, 2, 3'b011, 0, 0);
        step("mid_clr",   0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0);
        step("sync_clr1", 0, 0, 3'b000, 0, 0, 3'b000, 0, 0);
        step("sync_clr2", 0, 0, 3'b000, 0, 0, 3'b000, 0, 0);

        step("af0",     0, 1, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0);
        step("af1",     0, 1, 3'b000, 1, 1, 3'b001, 0, 0, 1, 0);
        step("af2",     0, 1, 3'b000, 1, 2, 3'b011, 0, 0, 2, 0);
        step("af3",     0, 0, 3'b000, 0, 3, 3'b010, 0, 0, 3, 1);
        step("af_hold", 0, 0, 3'b000, 0, 3, 3'b010, 0, 0, 3, 1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge wr_clk);
        end
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation ran past 50000 time units");
        $fatal(1, "timeout");
    end

endmodule
